// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard destination tracker.
package hazard_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned CNT_W      = 16;

   // One pipeline stage record: destination register and its write-back enable.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] dest;
      logic                  wb_en;
   } stage_t;

   // Empty slot: never writes the register file, so it can never raise a hazard.
   localparam stage_t BUBBLE = '{dest: '0, wb_en: 1'b0};

endpackage

// File: rtl/dest_stage_reg.sv
// Single pipeline stage register for {dest, wb_en} with load, hold and bubble controls.
module dest_stage_reg
   import hazard_pkg::*;
(
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   load_i,   // 0 = hold current contents
   input  logic   bubble_i, // when loading, insert BUBBLE instead of d_i
   input  stage_t d_i,
   output stage_t q_o
);

   stage_t stage_d, stage_q;

   // Select the next record: hold, bubble or load.
   always_comb begin
      stage_d = stage_q;
      if (load_i) begin
         stage_d = bubble_i ? BUBBLE : d_i;
      end
   end

   // Stage register with synchronous reset to an empty slot.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stage_q <= BUBBLE;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign q_o = stage_q;

endmodule

// File: rtl/hazard_dest_tracker.sv
// Tracks destination/write-enable of in-flight instructions through EXE, MEM and WB,
// inserts hazard and flush bubbles into EXE, and freezes IF/ID on hazards or memory waits.
module hazard_dest_tracker
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = hazard_pkg::REG_ADDR_W,
   parameter int unsigned CNT_W      = hazard_pkg::CNT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_dest,
   input  logic                  id_wb_en,
   input  logic                  id_valid,
   input  logic                  hazard_detected,
   input  logic                  flush,
   input  logic                  mem_ready,
   output logic [REG_ADDR_W-1:0] exe_dest,
   output logic [REG_ADDR_W-1:0] mem_dest,
   output logic [REG_ADDR_W-1:0] wb_dest,
   output logic                  exe_wb_en,
   output logic                  mem_wb_en,
   output logic                  wb_wb_en,
   output logic                  freeze_if_id,
   output logic [CNT_W-1:0]      bubble_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   stage_t id_rec;
   stage_t exe_q, mem_q, wb_q;
   logic   advance;
   logic   exe_bubble;

   logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
   logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

   // A busy data memory stalls the whole tracker.
   assign advance    = mem_ready;
   // Flush, hazard and an empty ID slot all load a bubble into EXE.
   assign exe_bubble = flush | hazard_detected | ~id_valid;
   // id_dest is registered unchanged even when id_wb_en is low.
   assign id_rec     = '{dest: id_dest, wb_en: id_wb_en};

   dest_stage_reg u_exe_stage (
      .clk_i   (clk),
      .rst_i   (rst),
      .load_i  (advance),
      .bubble_i(exe_bubble),
      .d_i     (id_rec),
      .q_o     (exe_q)
   );

   dest_stage_reg u_mem_stage (
      .clk_i   (clk),
      .rst_i   (rst),
      .load_i  (advance),
      .bubble_i(1'b0),
      .d_i     (exe_q),
      .q_o     (mem_q)
   );

   dest_stage_reg u_wb_stage (
      .clk_i   (clk),
      .rst_i   (rst),
      .load_i  (advance),
      .bubble_i(1'b0),
      .d_i     (mem_q),
      .q_o     (wb_q)
   );

   // Saturating statistics; flush takes priority so a flushed hazard is not double counted.
   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      if (advance) begin
         if (flush) begin
            if (flush_cnt_q != CntMax) flush_cnt_d = flush_cnt_q + 1'b1;
         end else if (hazard_detected) begin
            if (bubble_cnt_q != CntMax) bubble_cnt_d = bubble_cnt_q + 1'b1;
         end
      end
   end

   // Counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_cnt_q <= '0;
         flush_cnt_q  <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   // Freeze is combinational so the hazard loop keeps exactly one register.
   assign freeze_if_id = hazard_detected | ~mem_ready;

   assign exe_dest   = exe_q.dest;
   assign mem_dest   = mem_q.dest;
   assign wb_dest    = wb_q.dest;
   assign exe_wb_en  = exe_q.wb_en;
   assign mem_wb_en  = mem_q.wb_en;
   assign wb_wb_en   = wb_q.wb_en;
   assign bubble_cnt = bubble_cnt_q;
   assign flush_cnt  = flush_cnt_q;

endmodule
